// File: rtl/operand_fetch_if.sv
// Bundle of handshake and bus signals around the operand_fetch stage.
//
// Groups:
//   upstream   : in_valid, in_instr -> stage; in_ready <- stage
//   reg file   : rd_addrA/B <- stage; rd_dataA/B -> stage
//   writeback  : wb_en, wb_addr, wb_data -> stage
//   execute    : out_valid and decoded bundle <- stage; out_ready -> stage
//
// Modports:
//   slave  : the operand_fetch stage itself
//   master : the surrounding environment (upstream, register file, writeback, execute)
interface operand_fetch_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;

  logic [4:0]  rd_addrA;
  logic [4:0]  rd_addrB;
  logic [31:0] rd_dataA;
  logic [31:0] rd_dataB;

  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [15:0] out_imm;
  logic [31:0] out_srcA;
  logic [31:0] out_srcB;
  logic [4:0]  out_dest;

  modport slave (
    input  in_valid, in_instr, rd_dataA, rd_dataB,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, rd_addrA, rd_addrB,
    output out_valid, out_opcode, out_funct, out_imm, out_srcA, out_srcB, out_dest
  );

  modport master (
    output in_valid, in_instr, rd_dataA, rd_dataB,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, rd_addrA, rd_addrB,
    input  out_valid, out_opcode, out_funct, out_imm, out_srcA, out_srcB, out_dest
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: MIPS decode / operand-fetch stage in front of a 32x32
// register file. Accepts one instruction per cycle, drives the register file
// read addresses from rs/rt, captures operands into a one-entry output
// register for execute, and stalls on registers with an in-flight write
// (32-entry scoreboard cleared by the writeback port).
//
// Ports:
//   elk       : clock, rising edge
//   nrst      : asynchronous reset, active-high despite its name
//   bus       : operand_fetch_if.slave (upstream handshake, register file,
//               writeback, execute bundle)
//   stall_cnt : saturating count of cycles stalled by a hazard
//
// Build option:
//   OPFETCH_BYPASS_EN : when defined, a source being written back in the
//                       same cycle is forwarded from wb_data instead of
//                       stalling. Undefined (default) means no forwarding.
module operand_fetch #(
  parameter int STALL_W = 16
) (
  input  logic               elk,
  input  logic               nrst,
  operand_fetch_if.slave     bus,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [31:0]        sb_q, sb_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [5:0]         opcode_q, opcode_d;
  logic [5:0]         funct_q, funct_d;
  logic [15:0]        imm_q, imm_d;
  logic [31:0]        srca_q, srca_d;
  logic [31:0]        srcb_q, srcb_d;
  logic [4:0]         dest_q, dest_d;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt, dest;
  logic        uses_rt;
  logic        byp_a, byp_b;
  logic        hazard;
  logic        in_ready_s;
  logic        accept;
  logic [31:0] src_a, src_b;

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    if (v == {STALL_W{1'b1}})
      return v;
    else
      return v + {{(STALL_W-1){1'b0}}, 1'b1};
  endfunction

  // Field decode; destination 0 means "no destination".
  always_comb begin
    opcode  = bus.in_instr[31:26];
    rs      = bus.in_instr[25:21];
    rt      = bus.in_instr[20:16];
    uses_rt = (opcode == 6'h00) || (opcode == 6'h04) ||
              (opcode == 6'h05) || (opcode == 6'h2B);
    if (opcode == 6'h00)
      dest = bus.in_instr[15:11];
    else if (((opcode >= 6'h08) && (opcode <= 6'h0F)) || (opcode == 6'h23))
      dest = rt;
    else
      dest = 5'd0;
  end

`ifdef OPFETCH_BYPASS_EN
  // A source retired this very cycle is forwarded from the writeback bus.
  assign byp_a = bus.wb_en && (bus.wb_addr == rs);
  assign byp_b = bus.wb_en && (bus.wb_addr == rt);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  // Scoreboard bit 0 is never set, so $0 never raises a hazard. The WAW check
  // on the destination is never relieved by forwarding.
  assign hazard = (sb_q[rs] && !byp_a) ||
                  (uses_rt && sb_q[rt] && !byp_b) ||
                  sb_q[dest];

  assign src_a = (rs == 5'd0) ? 32'd0 : (byp_a ? bus.wb_data : bus.rd_dataA);
  assign src_b = (rt == 5'd0) ? 32'd0 : (byp_b ? bus.wb_data : bus.rd_dataB);

  assign accept = bus.in_valid && in_ready_s;

  // State register (with all other flops)
  always_ff @(posedge elk or posedge nrst) begin
    if (nrst) begin
      state_q  <= EMPTY;
      sb_q     <= '0;
      stall_q  <= '0;
      opcode_q <= '0;
      funct_q  <= '0;
      imm_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      dest_q   <= '0;
    end else begin
      state_q  <= state_d;
      sb_q     <= sb_d;
      stall_q  <= stall_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      imm_q    <= imm_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      dest_q   <= dest_d;
    end
  end

  // Next-state logic of the output register
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (bus.out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Output logic; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready_s = !nrst && !hazard && ((state_q == EMPTY) || bus.out_ready);
  end

  // Scoreboard, stall counter and bundle capture
  always_comb begin
    sb_d = sb_q;
    // Clear before set so that a same-cycle set of the same register wins.
    if (bus.wb_en)
      sb_d[bus.wb_addr] = 1'b0;
    if (accept && (dest != 5'd0))
      sb_d[dest] = 1'b1;

    stall_d = (bus.in_valid && hazard) ? sat_inc(stall_q) : stall_q;

    opcode_d = opcode_q;
    funct_d  = funct_q;
    imm_d    = imm_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    dest_d   = dest_q;
    if (accept) begin
      opcode_d = opcode;
      funct_d  = bus.in_instr[5:0];
      imm_d    = bus.in_instr[15:0];
      srca_d   = src_a;
      srcb_d   = src_b;
      dest_d   = dest;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.rd_addrA   = rs;
  assign bus.rd_addrB   = rt;
  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_opcode = opcode_q;
  assign bus.out_funct  = funct_q;
  assign bus.out_imm    = imm_q;
  assign bus.out_srcA   = srca_q;
  assign bus.out_srcB   = srcb_q;
  assign bus.out_dest   = dest_q;
  assign stall_cnt      = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: cycle driver with a behavioural model that
// predicts in_ready / stall_cnt and queues expected bundles; a separate
// monitor pops and compares whenever the stage presents a bundle.
module tb_operand_fetch;

  localparam int SW = 4;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam logic [31:0] ADDI8    = 32'h2008_0005; // addi $8,$0,5
  localparam logic [31:0] ADD9     = 32'h0108_4820; // add  $9,$8,$8
  localparam logic [31:0] ADD10    = 32'h0022_5020; // add  $10,$1,$2
  localparam logic [31:0] ADD0     = 32'h0022_0020; // add  $0,$1,$2
  localparam logic [31:0] ADD3_0_0 = 32'h0000_1820; // add  $3,$0,$0
  localparam logic [31:0] ADD11    = 32'h0120_5820; // add  $11,$9,$0

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
  } bundle_t;

  logic          clk;
  logic          rst;
  logic [SW-1:0] stall_cnt;
  logic [31:0]   rf [32];

  operand_fetch_if bus ();

  operand_fetch #(.STALL_W(SW)) dut (
    .elk       (clk),
    .nrst      (rst),
    .bus       (bus),
    .stall_cnt (stall_cnt)
  );

  assign bus.rd_dataA = rf[bus.rd_addrA];
  assign bus.rd_dataB = rf[bus.rd_addrB];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      total = 0;
  int      bad   = 0;
  bundle_t exp_q[$];
  bit      pend[32];
  bit      m_full;
  int      m_stall;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit uses_rt(input int op);
    return (op == 0) || (op == 4) || (op == 5) || (op == 43);
  endfunction

  function automatic int dest_of(input logic [31:0] ins);
    int op;
    op = int'(ins[31:26]);
    if (op == 0) return int'(ins[15:11]);
    if ((op >= 8 && op <= 15) || op == 35) return int'(ins[20:16]);
    return 0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    foreach (pend[i]) pend[i] = 1'b0;
    m_full  = 1'b0;
    m_stall = 0;
  endtask

  // One clock cycle: drive at the falling edge, check and update the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd,
                      input logic ordy, output bit acc);
    int      op, rs, rt, d;
    bit      ba, bb, haz, rdy;
    bundle_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.wb_en     = we;
    bus.wb_addr   = wa;
    bus.wb_data   = wd;
    bus.out_ready = ordy;
    #1;
    op  = int'(ins[31:26]);
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    d   = dest_of(ins);
    ba  = BYP && we && (int'(wa) == rs);
    bb  = BYP && we && (int'(wa) == rt);
    haz = (rs != 0 && pend[rs] && !ba) ||
          (uses_rt(op) && rt != 0 && pend[rt] && !bb) ||
          (d != 0 && pend[d]);
    rdy = !haz && (!m_full || ordy);
    chk("in_ready", bus.in_ready, rdy);
    chk("stall_cnt", stall_cnt, m_stall);
    if (v) begin
      chk("rd_addrA", bus.rd_addrA, ins[25:21]);
      chk("rd_addrB", bus.rd_addrB, ins[20:16]);
    end
    acc = v && rdy;
    if (acc) begin
      e.op  = ins[31:26];
      e.fn  = ins[5:0];
      e.imm = ins[15:0];
      e.a   = (rs == 0) ? 32'd0 : (ba ? wd : rf[rs]);
      e.b   = (rt == 0) ? 32'd0 : (bb ? wd : rf[rt]);
      e.d   = 5'(d);
      exp_q.push_back(e);
    end
    if (we) pend[wa] = 1'b0;
    if (acc && d != 0) pend[d] = 1'b1;
    if (v && haz) m_stall = (m_stall == (1 << SW) - 1) ? m_stall : m_stall + 1;
    m_full = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 9))
      0, 1:    op = 6'h00;
      2:       op = 6'h04;
      3:       op = 6'h05;
      4:       op = 6'h2B;
      5:       op = 6'h23;
      6, 7:    op = 6'(8 + $urandom_range(0, 7));
      8:       op = 6'h02;
      default: op = 6'(16 + $urandom_range(0, 15));
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 6'($urandom)};
  endfunction

  // Monitor: compare the presented bundle with the head of the queue every
  // cycle it is valid (checks stability too); pop when execute takes it.
  always @(negedge clk) begin
    #2;
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0)
        chk("out_valid_unexpected", bus.out_valid, 1'b0);
      else begin
        chk("bundle", {bus.out_opcode, bus.out_funct, bus.out_imm,
                       bus.out_srcA, bus.out_srcB, bus.out_dest}, exp_q[0]);
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    foreach (rf[i]) rf[i] = $urandom;
    rf[0] = 32'hFFFF_FFFF;
    rf[8] = 32'h8888_0008;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.wb_en     = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;
    bus.out_ready = 1'b0;
    model_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_data", {bus.out_opcode, bus.out_funct, bus.out_imm,
                     bus.out_srcA, bus.out_srcB, bus.out_dest}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // RAW on $8: stall until writeback retires it.
    step(1, ADDI8, 0, 0, 0, 1, acc);
    chk("addi_accept", acc, 1'b1);
    repeat (3) step(1, ADD9, 0, 0, 0, 1, acc);
    step(1, ADD9, 1, 5'd8, 32'h0000_0005, 1, acc);
    chk("raw_bypass_accept", acc, BYP);
    if (!acc) step(1, ADD9, 0, 0, 0, 1, acc);
    chk("raw_accept", acc, 1'b1);

    // Backpressure: bundle held for 3 cycles, then accepted on release.
    repeat (3) step(1, ADD10, 0, 0, 0, 0, acc);
    step(1, ADD10, 0, 0, 0, 1, acc);
    chk("release_accept", acc, 1'b1);

    // $0 destination and $0 source.
    step(1, ADD0, 0, 0, 0, 1, acc);
    step(1, ADD3_0_0, 0, 0, 0, 1, acc);
    step(1, ADD0, 0, 0, 0, 1, acc);
    chk("rd0_no_waw", acc, 1'b1);

    // Long hazard on $9 saturates the counter.
    repeat (20) step(1, ADD11, 0, 0, 0, 1, acc);
    #1;
    chk("stall_sat", stall_cnt, 15);

    // Reset while FULL with $8 pending.
    step(1, ADDI8, 0, 0, 0, 0, acc);
    step(0, 0, 0, 0, 0, 0, acc);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_dest", bus.out_dest, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, ADD9, 0, 0, 0, 1, acc);
    chk("post_rst_no_hazard", acc, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa;
      bit         we;
      wa = 5'($urandom_range(1, 7));
      we = pend[wa] && ($urandom_range(0, 2) == 0);
      step(1'($urandom_range(0, 3) != 0), rand_instr(), we, wa, $urandom,
           1'($urandom_range(0, 3) != 0), acc);
    end

    repeat (3) step(0, 0, 0, 0, 0, 1, acc);
    chk("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode/operand-fetch stage directly upstream of the 32×32 register file. Accepts one 32-bit MIPS instruction per cycle over a valid/ready handshake, drives the register file read addresses from the rs/rt fields, and captures the returned operands into an output pipeline register for the execute stage. A 32-entry scoreboard tracks registers with an in-flight write and stalls any instruction that reads or re-targets one until the writeback port retires it.

## Interface
Parameters:
- `STALL_W`, 16: width of the saturating stall-cycle counter.

Ports:
- `elk` in 1: clock; all state updates on the rising edge.
- `nrst` in 1: reset, asynchronous, active-high (asserted = 1, despite the name).
- `in_valid` in 1: upstream instruction valid.
- `in_instr` in 32: instruction word.
- `in_ready` out 1: stage accepts `in_instr` this cycle.
- `rd_addrA` out 5: register file read address A (= rs, `in_instr[25:21]`).
- `rd_addrB` out 5: register file read address B (= rt, `in_instr[20:16]`).
- `rd_dataA` in 32: register file read data A.
- `rd_dataB` in 32: register file read data B.
- `wb_en` in 1: writeback retiring a register this cycle.
- `wb_addr` in 5: register being written back.
- `wb_data` in 32: writeback value.
- `out_valid` out 1: execute-stage bundle valid.
- `out_ready` in 1: execute stage accepts bundle.
- `out_opcode` out 6, `out_funct` out 6, `out_imm` out 16: decoded fields.
- `out_srcA` out 32, `out_srcB` out 32: operand values.
- `out_dest` out 5: destination register (0 = none).
- `stall_cnt` out `STALL_W`: cycles with `in_valid`=1 and `in_ready`=0 due to hazard.

## Operation
- Read addresses are combinational from `in_instr`, valid whenever `in_valid`=1.
- Source use: rs always; rt when opcode is 0x00, 0x04, 0x05 or 0x2B.
- Destination: opcode 0x00 -> rd (`[15:11]`); opcodes 0x08–0x0F, 0x23 -> rt; otherwise none. Destination 0 is treated as none.
- Hazard: any used source, or the destination, has its scoreboard bit set. Register 0 is never pending.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on accept; FULL->EMPTY on `out_ready` with no accept; FULL->FULL on `out_ready` and accept, or while `out_ready`=0.
- `in_ready` = !hazard && (EMPTY || `out_ready`).
- Accept (`in_valid && in_ready`): latch fields and operands; set scoreboard bit for destination.
- Writeback: `wb_en` clears bit `wb_addr`. Same-cycle set and clear of one register: set wins.
- Register 0 operands are forced to 0 regardless of `rd_dataA/B`.
- `stall_cnt` saturates at all-ones; it does not wrap.

## Timing
- Reset: `out_valid`=0, `in_ready`=0 while asserted, all `out_*` data 0, `out_dest`=0, scoreboard all clear, `stall_cnt`=0. Reset mid-transfer drops the in-flight bundle; no scoreboard bits survive.
- Latency: accept at edge N -> `out_valid`=1 after edge N; one cycle, full throughput with no hazards.
- Operands sampled at the accept edge; register file read data must settle within the cycle.
- Output bundle holds stable while `out_valid`=1 and `out_ready`=0.
- Hazard clear via `wb_en` at edge N: dependent instruction may be accepted at edge N+1 at earliest (without bypass).

## Configuration
- `OPFETCH_BYPASS_EN` defined: a source matching `wb_addr` with `wb_en`=1 in the same cycle is not a hazard; its operand is taken from `wb_data` instead of `rd_dataA/B`, and accept occurs in the writeback cycle (one cycle earlier). Destination WAW check unchanged.
- Undefined: no bypass; scoreboard clear takes effect only at the next edge, dependent instruction stalls that extra cycle.

## Test plan
- Reset asserted mid-FULL with scoreboard bit 8 set -> `out_valid`=0, scoreboard 0, `stall_cnt`=0 immediately, without clock.
- `addi $8,$0,5` then `add $9,$8,$8` back-to-back -> second stalls (`in_ready`=0, `stall_cnt` increments) until `wb_en`=1,`wb_addr`=8.
- With `OPFETCH_BYPASS_EN`, `wb_data`=0x0000_0005 in stall cycle -> accept that cycle, `out_srcA`=`out_srcB`=5; without it accept one cycle later with register file data.
- `out_ready`=0 for 3 cycles while FULL -> bundle stable, `in_ready`=0; release -> next instruction accepted same edge.
- Instruction with rd=0 (`add $0,$1,$2`) -> `out_dest`=0, no scoreboard bit set; source $0 reads 0 even if `rd_dataA`=0xFFFF_FFFF.
- Force hazard with `STALL_W`=4 for 20 cycles -> `stall_cnt` saturates at 15.
